// File: rtl/s4_regfile_writeback.sv
// s4_regfile_writeback: write-back stage, 32x32 register file with same-cycle bypass
// and a saturating committed-write counter.
module s4_regfile_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] S3_ALUOUT,
    input  logic [ADDR_W-1:0] S3_WS,
    input  logic              S3_WE,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] RDA,
    output logic [DATA_W-1:0] RDB,
    output logic              WB_COMMIT,
    output logic [CNT_W-1:0]  WB_COUNT
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              wr;
    assign wr = S3_WE && S3_WS != '0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
            WB_COMMIT <= 1'b0;
            WB_COUNT  <= '0;
        end else begin
            if (wr) mem[S3_WS] <= S3_ALUOUT;
            WB_COMMIT <= wr;
            if (wr && !(&WB_COUNT)) WB_COUNT <= WB_COUNT + CNT_W'(1);
        end
    // The in-flight S3 write beats the array; index 0 and reset force zero.
    always_comb begin
        RDA = (!rst || RA == '0) ? '0 : (S3_WE && S3_WS == RA) ? S3_ALUOUT : mem[RA];
        RDB = (!rst || RB == '0) ? '0 : (S3_WE && S3_WS == RB) ? S3_ALUOUT : mem[RB];
    end
endmodule
